// File: rtl/cirno9_ls_timer_if.sv
// Load/store SRAM-style port shared by the core and the machine timer.
// The core drives the request side; the responder returns registered data, hit and irq.
interface cirno9_ls_timer_if;
    logic        en;
    logic [3:0]  we;
    logic [31:0] adr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        hit;
    logic        irq;

    modport master (output en, output we, output adr, output din,
                    input  dout, input hit, input irq);
    modport slave  (input  en, input we, input adr, input din,
                    output dout, output hit, output irq);
endinterface

// File: rtl/cirno9_ls_timer.sv
// Memory-mapped 64-bit machine timer with prescaler, compare register and level irq.
// Answers the load/store port with the same one-cycle registered read latency as the SRAM.
module cirno9_ls_timer #(
    parameter logic [31:0] BASE_ADR   = 32'h0200_0000,
    parameter int          PRESCALE_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    cirno9_ls_timer_if.slave bus
);

    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  run_q, run_d;
    logic                  irq_en_q, irq_en_d;
    logic [PRESCALE_W-1:0] div_q, div_d;
    logic [PRESCALE_W-1:0] psc_q, psc_d;
    logic [31:0]           dout_q, dout_d;
    logic                  hit_q, hit_d;
    logic                  irq_q, irq_d;

    logic        sel, wr, rd, tick, pend;
    logic [2:0]  off;
    logic [31:0] wmask, ctrl_rd, ctrl_wr, rd_data;

    assign sel  = bus.en & (bus.adr[31:5] == BASE_ADR[31:5]);
    assign off  = bus.adr[4:2];
    assign wr   = sel & (bus.we != 4'b0000);
    assign rd   = sel & (bus.we == 4'b0000);
    assign tick = run_q & (psc_q == div_q);
    assign pend = (mtime_q >= mtimecmp_q);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wmask[8*gi +: 8] = {8{bus.we[gi]}};
        end
    endgenerate

    function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                                input logic [31:0] wdat,
                                                input logic [31:0] msk);
        return (cur & ~msk) | (wdat & msk);
    endfunction

    always_comb begin
        ctrl_rd                  = '0;
        ctrl_rd[0]               = run_q;
        ctrl_rd[1]               = irq_en_q;
        ctrl_rd[8 +: PRESCALE_W] = div_q;
    end

    assign ctrl_wr = merge_lanes(ctrl_rd, bus.din, wmask);

    always_comb begin
        rd_data = '0;
        case (off)
            3'd0:    rd_data = mtime_q[31:0];
            3'd1:    rd_data = mtime_q[63:32];
            3'd2:    rd_data = mtimecmp_q[31:0];
            3'd3:    rd_data = mtimecmp_q[63:32];
            3'd4:    rd_data = ctrl_rd;
            3'd5:    rd_data = {31'd0, pend};
            default: rd_data = '0;
        endcase
    end

    always_comb begin
        mtime_d    = mtime_q;
        mtimecmp_d = mtimecmp_q;
        run_d      = run_q;
        irq_en_d   = irq_en_q;
        div_d      = div_q;
        psc_d      = '0;
        dout_d     = rd ? rd_data : dout_q;
        hit_d      = sel;
        irq_d      = irq_en_q & pend;

        if (run_q) begin
            psc_d = tick ? '0 : psc_q + 1'b1;
        end

        // A counter write replaces the increment for the whole 64 bits that cycle.
        if (wr && off == 3'd0) begin
            mtime_d[31:0] = merge_lanes(mtime_q[31:0], bus.din, wmask);
        end else if (wr && off == 3'd1) begin
            mtime_d[63:32] = merge_lanes(mtime_q[63:32], bus.din, wmask);
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end

        if (wr && off == 3'd2) begin
            mtimecmp_d[31:0] = merge_lanes(mtimecmp_q[31:0], bus.din, wmask);
        end
        if (wr && off == 3'd3) begin
            mtimecmp_d[63:32] = merge_lanes(mtimecmp_q[63:32], bus.din, wmask);
        end

        if (wr && off == 3'd4) begin
            run_d    = ctrl_wr[0];
            irq_en_d = ctrl_wr[1];
            div_d    = ctrl_wr[8 +: PRESCALE_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            run_q      <= 1'b0;
            irq_en_q   <= 1'b0;
            div_q      <= '0;
            psc_q      <= '0;
            dout_q     <= '0;
            hit_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            run_q      <= run_d;
            irq_en_q   <= irq_en_d;
            div_q      <= div_d;
            psc_q      <= psc_d;
            dout_q     <= dout_d;
            hit_q      <= hit_d;
            irq_q      <= irq_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.hit  = hit_q;
    assign bus.irq  = irq_q;

    // Byte-offset bits and the non-field CTRL bits carry no state.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.adr[1:0], ctrl_wr};

endmodule

// File: tb/tb_cirno9_ls_timer.sv
// Directed bench for cirno9_ls_timer: a register-level reference model checked every
// cycle, plus literal expectations for each access scenario.
module tb_cirno9_ls_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF03;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic check_on;

    cirno9_ls_timer_if bus ();

    cirno9_ls_timer #(.BASE_ADR(BASE), .PRESCALE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the register file as software sees it.
    logic [63:0] m_mtime, m_cmp;
    logic [31:0] m_ctrl;
    int unsigned m_phase;
    logic [31:0] m_dout;
    logic        m_hit, m_irq;

    logic        m_sel, m_wr, m_tick;
    logic [2:0]  m_off;
    assign m_sel  = bus.en && (bus.adr[31:5] == BASE[31:5]);
    assign m_off  = bus.adr[4:2];
    assign m_wr   = m_sel && (bus.we != 4'b0000);
    assign m_tick = m_ctrl[0] && (m_phase == int'(m_ctrl[15:8]));

    function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] m_reg(input logic [2:0] o, input logic [63:0] t,
                                          input logic [63:0] c, input logic [31:0] k);
        case (o)
            3'd0: return t[31:0];
            3'd1: return t[63:32];
            3'd2: return c[31:0];
            3'd3: return c[63:32];
            3'd4: return k;
            3'd5: return {31'd0, (t >= c)};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mtime <= 64'd0;
            m_cmp   <= {64{1'b1}};
            m_ctrl  <= 32'd0;
            m_phase <= 0;
            m_dout  <= 32'd0;
            m_hit   <= 1'b0;
            m_irq   <= 1'b0;
        end else begin
            if (m_wr && m_off == 3'd0)
                m_mtime <= {m_mtime[63:32], lanes(m_mtime[31:0], bus.din, bus.we)};
            else if (m_wr && m_off == 3'd1)
                m_mtime <= {lanes(m_mtime[63:32], bus.din, bus.we), m_mtime[31:0]};
            else if (m_tick)
                m_mtime <= m_mtime + 64'd1;
            if (m_wr && m_off == 3'd2)
                m_cmp <= {m_cmp[63:32], lanes(m_cmp[31:0], bus.din, bus.we)};
            if (m_wr && m_off == 3'd3)
                m_cmp <= {lanes(m_cmp[63:32], bus.din, bus.we), m_cmp[31:0]};
            if (m_wr && m_off == 3'd4)
                m_ctrl <= lanes(m_ctrl, bus.din, bus.we) & CTRL_MASK;
            m_phase <= (!m_ctrl[0] || m_tick) ? 0 : m_phase + 1;
            if (m_sel && bus.we == 4'b0000)
                m_dout <= m_reg(m_off, m_mtime, m_cmp, m_ctrl);
            m_hit <= m_sel;
            m_irq <= m_ctrl[1] && (m_mtime >= m_cmp);
        end
    end

    always @(negedge clk) begin
        if (rst_n && check_on) begin
            n_cmp = n_cmp + 1;
            if (bus.dout !== m_dout || bus.hit !== m_hit || bus.irq !== m_irq) begin
                n_err = n_err + 1;
                $display("FAIL cycle_model: dout=%h hit=%b irq=%b, required dout=%h hit=%b irq=%b",
                         bus.dout, bus.hit, bus.irq, m_dout, m_hit, m_irq);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Each access task starts and ends on a falling edge.
    task automatic wr_acc(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        bus.en = 1'b1; bus.we = be; bus.adr = a; bus.din = d;
        @(negedge clk);
        bus.en = 1'b0; bus.we = 4'b0000;
        $display("write adr=%h we=%b din=%h", a, be, d);
    endtask

    task automatic rd_acc(input logic [31:0] a, output logic [31:0] d, output logic h);
        bus.en = 1'b1; bus.we = 4'b0000; bus.adr = a;
        @(negedge clk);
        bus.en = 1'b0;
        d = bus.dout;
        h = bus.hit;
        $display("read  adr=%h dout=%h hit=%b irq=%b", a, d, h, bus.irq);
    endtask

    task automatic rd_check(input string name, input logic [2:0] o, input logic [31:0] exp);
        logic [31:0] d;
        logic        h;
        rd_acc(BASE + {27'd0, o, 2'b00}, d, h);
        check(name, d, exp);
        check({name, "_hit"}, {31'd0, h}, 32'd1);
    endtask

    logic [31:0] rd_v;
    logic        rd_h;
    int          cnt;

    initial begin
        n_cmp = 0; n_err = 0; check_on = 1'b0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.we = 4'b0000; bus.adr = 32'd0; bus.din = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_dout", bus.dout, 32'd0);
        check("rst_hit_irq", {30'd0, bus.hit, bus.irq}, 32'd0);
        rst_n = 1'b1;
        check_on = 1'b1;

        for (int o = 0; o < 8; o++)
            rd_check("reset_read", o[2:0], (o == 2 || o == 3) ? 32'hFFFF_FFFF : 32'd0);
        check("reset_irq", {31'd0, bus.irq}, 32'd0);

        // Prescaled run, div=3: one tick every 4 cycles.
        wr_acc(BASE + 32'h10, 4'hF, 32'h0000_0301);
        repeat (40) @(negedge clk);
        rd_acc(BASE + 32'h00, rd_v, rd_h);
        n_cmp = n_cmp + 1;
        if (rd_v < 32'd9 || rd_v > 32'd11) begin
            n_err = n_err + 1;
            $display("FAIL div3_count: got %0d, required 10 +/- 1", rd_v);
        end
        wr_acc(BASE + 32'h10, 4'hF, 32'h0000_0000);

        // LO->HI carry on a single tick.
        wr_acc(BASE + 32'h00, 4'hF, 32'hFFFF_FFFF);
        wr_acc(BASE + 32'h04, 4'hF, 32'h0000_0000);
        wr_acc(BASE + 32'h10, 4'hF, 32'h0000_0001);
        wr_acc(BASE + 32'h10, 4'hF, 32'h0000_0000);
        rd_check("carry_hi", 3'd1, 32'd1);
        rd_check("carry_lo", 3'd0, 32'd0);

        // Compare and interrupt timing.
        wr_acc(BASE + 32'h00, 4'hF, 32'd0);
        wr_acc(BASE + 32'h04, 4'hF, 32'd0);
        wr_acc(BASE + 32'h0C, 4'hF, 32'd0);
        wr_acc(BASE + 32'h08, 4'hF, 32'd20);
        wr_acc(BASE + 32'h10, 4'hF, 32'h0000_0003);
        cnt = 0;
        while (!bus.irq && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        check("irq_rise_cycles", cnt, 32'd21);
        rd_check("status_pend", 3'd5, 32'd1);
        wr_acc(BASE + 32'h08, 4'hF, 32'd100);
        check("irq_hold_after_write", {31'd0, bus.irq}, 32'd1);
        @(negedge clk);
        check("irq_fall", {31'd0, bus.irq}, 32'd0);
        wr_acc(BASE + 32'h10, 4'hF, 32'h0000_0000);
        rd_check("status_clear", 3'd5, 32'd0);

        // Single byte lane write.
        wr_acc(BASE + 32'h08, 4'hF, 32'hFFFF_FFFF);
        wr_acc(BASE + 32'h08, 4'b0100, 32'h00AB_0000);
        rd_check("byte_lane", 3'd2, 32'hFFAB_FFFF);

        // Outside the window: no hit, dout held, aliases untouched.
        rd_acc(BASE + 32'd32, rd_v, rd_h);
        check("outside_hit", {31'd0, rd_h}, 32'd0);
        check("outside_dout_held", rd_v, 32'hFFAB_FFFF);
        wr_acc(BASE + 32'd40, 4'hF, 32'hDEAD_BEEF);
        rd_check("outside_no_write", 3'd2, 32'hFFAB_FFFF);

        // Reset landing on a write cycle.
        bus.en = 1'b1; bus.we = 4'hF; bus.adr = BASE + 32'h08; bus.din = 32'h1234_5678;
        #2 rst_n = 1'b0;
        @(negedge clk);
        bus.en = 1'b0; bus.we = 4'b0000;
        $display("reset during write adr=%h din=%h", bus.adr, bus.din);
        check("midrst_dout", bus.dout, 32'd0);
        check("midrst_hit_irq", {30'd0, bus.hit, bus.irq}, 32'd0);
        rst_n = 1'b1;
        rd_check("midrst_cmp_lo", 3'd2, 32'hFFFF_FFFF);
        rd_check("midrst_ctrl", 3'd4, 32'd0);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cirno9_ls_timer.md
# cirno9_ls_timer

Memory-mapped 64-bit machine timer that answers the core's load/store SRAM-style port as a responder, alongside the data SRAM. It uses the same en/we/adr/din/dout handshake and the same one-cycle registered read latency as the SRAM, so it can share the core's port through a simple address split. It provides a prescaled free-running 64-bit counter, a 64-bit compare register, and a level interrupt to the core.

## Interface
- BASE_ADR, 32'h0200_0000, base byte address of the 32-byte register window; must be 32-byte aligned.
- PRESCALE_W, 8, width of the prescaler divide field and counter.

- clk  in  1  single clock; all state is on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  access strobe from the core; one access per cycle while high.
- we  in  4  byte write enables; 4'b0000 with en=1 is a read.
- adr  in  32  byte address; adr[1:0] ignored.
- din  in  32  write data; byte lane i is din[8i+7:8i].
- dout  out  32  registered read data.
- hit  out  1  registered: previous cycle's access was inside the window. Used by the port mux to select dout.
- irq  out  1  timer interrupt, level, registered.

## Operation
- Select: sel = en & (adr[31:5] == BASE_ADR[31:5]). Word offset = adr[4:2].
- Register map (offset: register):
  - 0x00 MTIME_LO
  - 0x04 MTIME_HI
  - 0x08 MTIMECMP_LO
  - 0x0C MTIMECMP_HI
  - 0x10 CTRL: bit0 run, bit1 irq_en, bits[8+PRESCALE_W-1:8] div. Other bits read 0 and are not writable.
  - 0x14 STATUS: bit0 pend = (mtime >= mtimecmp), 64-bit unsigned compare. Read-only.
  - 0x18, 0x1C read 0; writes are ignored.
- Writes: when sel & (we != 0), each enabled byte lane of the addressed register takes din. Disabled lanes keep their current value.
- Reads: when sel & (we == 0), dout <= addressed register value sampled this cycle.
  - On a write, a non-selected access, or en=0, dout holds its previous value.
- hit <= sel, every cycle, for reads and writes alike.
- Prescaler: psc counter, PRESCALE_W bits, runs while run=1.
  - tick = run & (psc == div). On tick, psc <= 0; otherwise psc <= psc + 1.
  - div=0 gives a tick every cycle.
  - When run=0, psc is held at 0.
- Counter: on tick, mtime <= mtime + 1 as a full 64-bit add. Carry propagates LO->HI. Wraps from 2^64-1 to 0.
- Write to MTIME_LO or MTIME_HI in a tick cycle: the write wins for the whole 64-bit counter that cycle.
  - Written bytes take din; all other bytes keep their pre-increment value.
  - No increment occurs that cycle.
- irq <= irq_en & pend, recomputed every cycle from the current register values.
  - Interrupt is cleared by writing mtimecmp above mtime, or by clearing irq_en.
- Reset values: mtime = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, CTRL = 0, psc = 0, dout = 0, hit = 0, irq = 0.
  - Reset is effective mid-access; an access in flight is dropped and no write commits.

## Timing
- Read latency is 1 cycle: with en/adr presented in cycle N, dout and hit are valid after the edge ending N, i.e. in cycle N+1.
- Back-to-back accesses are allowed every cycle; no stall or wait output exists.
- Write data is visible to a read issued in the next cycle (N+1 read returns the new value in N+2).
- Tick to counter change: mtime updates at the edge ending the tick cycle.
- irq lag: irq rises 1 cycle after pend becomes true, i.e. the cycle after the edge on which mtime reaches mtimecmp. Same 1-cycle lag on fall.
- A CTRL write that changes div takes effect on the next compare; psc is not reset by the write.
- 64-bit reads are not atomic. Software reads HI, LO, HI and retries on mismatch; no hardware latch is provided.

## Test plan
- Reset then read all 8 offsets:
  - -> MTIMECMP_LO and MTIMECMP_HI read 32'hFFFF_FFFF.
  - -> all others read 0.
  - -> hit is high in the cycle after each read; irq = 0.
- Write CTRL = 32'h0000_0301 (run, div=3), wait 40 cycles, read MTIME_LO -> 10 ±1. Tick spacing is exactly 4 cycles.
- Write MTIME_LO = 32'hFFFF_FFFF with MTIME_HI = 0, then run with div=0 -> after one tick, HI = 1 and LO = 0.
- Write MTIMECMP = 20, CTRL = 32'h3:
  - -> irq rises exactly 1 cycle after mtime reaches 20; STATUS reads 1.
  - Write MTIMECMP_LO = 100 -> irq falls 1 cycle after the write edge.
- Byte-lane write with we = 4'b0100, din = 32'h00AB_0000 to MTIMECMP_LO (prior value 32'hFFFF_FFFF) -> reads 32'hFFAB_FFFF.
- Access outside the window (adr = BASE_ADR + 32) -> hit = 0, dout unchanged, no register changes.
- Assert rst_n mid-write -> no commit; all outputs at reset values.
